// File: rtl/oled_pkg.sv
// Shared constants, control codes, FSM encoding and cell-to-pixel helpers
// for the OLED text scheduler.
package oled_pkg;

  localparam int COLS          = 16;
  localparam int ROWS          = 4;
  localparam int CHAR_W        = 8;
  localparam int PAGES_PER_ROW = 2;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_BLANK = 8'h20;
  localparam logic [7:0] PRINT_LO    = 8'h20;
  localparam logic [7:0] PRINT_HI    = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT      = 3'd3,
    ST_CLR_ISSUE = 3'd4,
    ST_CLR_WAIT  = 3'd5
  } oled_state_e;

  function automatic logic [6:0] cell_x(input logic [3:0] col);
    return 7'(int'(col) * CHAR_W);
  endfunction

  function automatic logic [3:0] cell_y(input logic [1:0] row);
    return 4'(int'(row) * PAGES_PER_ROW);
  endfunction

endpackage

// File: rtl/oled_byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through read data.
// Pushes while full and pops while empty are dropped.
module oled_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk_50m,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_din,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == {(AW+1){1'b0}});
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array write port
  always_ff @(posedge clk_50m) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/oled_text_ctrl.sv
// Terminal-style front end for the 8x16 character generator: queues bytes,
// tracks the text cursor, draws printable characters and performs full-screen clears.
module oled_text_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int COLS        = oled_pkg::COLS,
  parameter int ROWS        = oled_pkg::ROWS,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_ascii,
  output logic       in_ready,
  input  logic       clr_req,
  output logic       cg_start,
  output logic [7:0] cg_ascii,
  output logic [6:0] cg_x,
  output logic [3:0] cg_y,
  input  logic       cg_done,
  output logic [3:0] cur_col,
  output logic [1:0] cur_row,
  output logic       idle,
  output logic       err_timeout
);

  import oled_pkg::*;

  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  oled_state_e r_state, w_state_n;
  logic [7:0]  r_cur_char;
  logic [3:0]  r_col, w_col_n, r_clr_col, w_clr_col_n;
  logic [1:0]  r_row, w_row_n, r_clr_row, w_clr_row_n;
  logic        r_pending, w_pending_n;
  logic [TW-1:0] r_tcnt, w_tcnt_n;
  logic        r_err, w_err_n;
  logic        w_pop, w_timeout;
  logic        r_cg_start;
  logic [7:0]  r_cg_ascii;
  logic [6:0]  r_cg_x;
  logic [3:0]  r_cg_y;
  logic [7:0]  w_fifo_dout;
  logic        w_fifo_full, w_fifo_empty;
  logic [CNTW-1:0] w_fifo_count;

  oled_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .i_push  (in_valid),
    .i_din   (in_ascii),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  function automatic logic [1:0] row_inc(input logic [1:0] row);
    if (row == 2'(ROWS - 1)) begin
      return 2'd0;
    end else begin
      return row + 2'd1;
    end
  endfunction

  assign w_timeout   = (r_tcnt == TW'(TIMEOUT_CYC - 1));
  assign in_ready    = !w_fifo_full;
  assign cg_start    = r_cg_start;
  assign cg_ascii    = r_cg_ascii;
  assign cg_x        = r_cg_x;
  assign cg_y        = r_cg_y;
  assign cur_col     = r_col;
  assign cur_row     = r_row;
  assign err_timeout = r_err;
  assign idle        = (r_state == ST_IDLE) && (w_fifo_count == {CNTW{1'b0}}) && !r_pending;

  // Next-state, cursor, clear-walk and timeout bookkeeping
  always_comb begin
    w_state_n   = r_state;
    w_col_n     = r_col;
    w_row_n     = r_row;
    w_clr_col_n = r_clr_col;
    w_clr_row_n = r_clr_row;
    w_pending_n = r_pending | clr_req;
    w_tcnt_n    = r_tcnt;
    w_err_n     = r_err;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pending) begin
          w_state_n   = ST_CLR_ISSUE;
          w_clr_col_n = 4'd0;
          w_clr_row_n = 2'd0;
        end else if (!w_fifo_empty) begin
          w_pop     = 1'b1;
          w_state_n = ST_DECODE;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_DECODE: begin
        w_state_n = ST_IDLE;
        if ((r_cur_char >= PRINT_LO) && (r_cur_char <= PRINT_HI)) begin
          w_state_n = ST_ISSUE;
        end else begin
          case (r_cur_char)
            ASCII_LF: begin
              w_col_n = 4'd0;
              w_row_n = row_inc(r_row);
            end
            ASCII_CR: w_col_n = 4'd0;
            ASCII_BS: begin
              if (r_col != 4'd0) begin
                w_col_n = r_col - 4'd1;
              end else begin
                w_col_n = 4'd0;
              end
            end
            ASCII_FF: w_pending_n = 1'b1;
            default:  w_state_n = ST_IDLE;
          endcase
        end
      end
      ST_ISSUE: begin
        w_tcnt_n  = {TW{1'b0}};
        w_state_n = ST_WAIT;
      end
      ST_WAIT: begin
        // A hung generator still advances the cursor so the stream keeps flowing
        if (cg_done || w_timeout) begin
          w_err_n   = r_err | !cg_done;
          w_state_n = ST_IDLE;
          if (r_col == 4'(COLS - 1)) begin
            w_col_n = 4'd0;
            w_row_n = row_inc(r_row);
          end else begin
            w_col_n = r_col + 4'd1;
          end
        end else begin
          w_tcnt_n = r_tcnt + TW'(1);
        end
      end
      ST_CLR_ISSUE: begin
        w_tcnt_n  = {TW{1'b0}};
        w_state_n = ST_CLR_WAIT;
      end
      ST_CLR_WAIT: begin
        if (cg_done || w_timeout) begin
          w_err_n = r_err | !cg_done;
          if ((r_clr_col == 4'(COLS - 1)) && (r_clr_row == 2'(ROWS - 1))) begin
            w_col_n     = 4'd0;
            w_row_n     = 2'd0;
            w_clr_col_n = 4'd0;
            w_clr_row_n = 2'd0;
            w_pending_n = 1'b0;
            w_state_n   = ST_IDLE;
          end else if (r_clr_col == 4'(COLS - 1)) begin
            w_clr_col_n = 4'd0;
            w_clr_row_n = row_inc(r_clr_row);
            w_state_n   = ST_CLR_ISSUE;
          end else begin
            w_clr_col_n = r_clr_col + 4'd1;
            w_state_n   = ST_CLR_ISSUE;
          end
        end else begin
          w_tcnt_n = r_tcnt + TW'(1);
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // State registers; generator outputs are loaded on entry to an issue state
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cur_char <= 8'h00;
      r_col      <= 4'd0;
      r_row      <= 2'd0;
      r_clr_col  <= 4'd0;
      r_clr_row  <= 2'd0;
      r_pending  <= 1'b0;
      r_tcnt     <= {TW{1'b0}};
      r_err      <= 1'b0;
      r_cg_start <= 1'b0;
      r_cg_ascii <= 8'h00;
      r_cg_x     <= 7'd0;
      r_cg_y     <= 4'd0;
    end else begin
      r_state    <= w_state_n;
      r_col      <= w_col_n;
      r_row      <= w_row_n;
      r_clr_col  <= w_clr_col_n;
      r_clr_row  <= w_clr_row_n;
      r_pending  <= w_pending_n;
      r_tcnt     <= w_tcnt_n;
      r_err      <= w_err_n;
      r_cg_start <= (w_state_n == ST_ISSUE) || (w_state_n == ST_CLR_ISSUE);
      if (w_pop) begin
        r_cur_char <= w_fifo_dout;
      end
      if (w_state_n == ST_ISSUE) begin
        r_cg_ascii <= r_cur_char;
        r_cg_x     <= cell_x(w_col_n);
        r_cg_y     <= cell_y(w_row_n);
      end else if (w_state_n == ST_CLR_ISSUE) begin
        r_cg_ascii <= ASCII_BLANK;
        r_cg_x     <= cell_x(w_clr_col_n);
        r_cg_y     <= cell_y(w_clr_row_n);
      end
    end
  end

endmodule

// File: tb/tb_oled_text_ctrl.sv
// Directed bench for oled_text_ctrl: a table of single-byte vectors plus
// hand-written sequences for latency, FIFO backpressure, clear, timeout and reset.
module tb_oled_text_ctrl;

  logic       clk_50m = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_ascii;
  logic       in_ready;
  logic       clr_req;
  logic       cg_start;
  logic [7:0] cg_ascii;
  logic [6:0] cg_x;
  logic [3:0] cg_y;
  logic       cg_done;
  logic [3:0] cur_col;
  logic [1:0] cur_row;
  logic       idle;
  logic       err_timeout;

  oled_text_ctrl #(.FIFO_DEPTH(4), .COLS(16), .ROWS(4), .TIMEOUT_CYC(100)) dut (
    .clk_50m     (clk_50m),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ascii    (in_ascii),
    .in_ready    (in_ready),
    .clr_req     (clr_req),
    .cg_start    (cg_start),
    .cg_ascii    (cg_ascii),
    .cg_x        (cg_x),
    .cg_y        (cg_y),
    .cg_done     (cg_done),
    .cur_col     (cur_col),
    .cur_row     (cur_row),
    .idle        (idle),
    .err_timeout (err_timeout)
  );

  always #10 clk_50m = ~clk_50m;

  int n_vec = 0;
  int n_bad = 0;
  int done_lat = 4;
  bit auto_done = 1'b0;

  logic [7:0] mon_a [$];
  logic [6:0] mon_x [$];
  logic [3:0] mon_y [$];

  typedef struct {
    logic [7:0] b;
    bit         draw;
    logic [6:0] x;
    logic [3:0] y;
    logic [3:0] col;
    logic [1:0] row;
  } vec_t;

  vec_t vt [17];

  // Record every start pulse with the coordinates presented alongside it
  always @(negedge clk_50m) begin
    if (rst_n && cg_start) begin
      mon_a.push_back(cg_ascii);
      mon_x.push_back(cg_x);
      mon_y.push_back(cg_y);
    end
  end

  // Character generator model: one-cycle done pulse done_lat cycles after start
  initial begin
    cg_done = 1'b0;
    @(negedge clk_50m);
    forever begin
      if (cg_start && auto_done) begin
        repeat (done_lat) @(negedge clk_50m);
        if (auto_done) cg_done = 1'b1;
        @(negedge clk_50m);
        cg_done = 1'b0;
      end else begin
        @(negedge clk_50m);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    int g = 0;
    while (!in_ready && g < 1000) begin
      @(negedge clk_50m);
      g++;
    end
    if (!in_ready) check("push_ready", in_ready, 1);
    in_valid = 1'b1;
    in_ascii = b;
    @(negedge clk_50m);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int g = 0;
    while (!idle && g < max) begin
      @(negedge clk_50m);
      g++;
    end
    check(name, idle, 1);
  endtask

  task automatic wait_start(input string name, input int max);
    int g = 0;
    do begin
      @(negedge clk_50m);
      g++;
    end while (!cg_start && g < max);
    check(name, cg_start, 1);
  endtask

  task automatic do_reset();
    auto_done = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    clr_req   = 1'b0;
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    @(negedge clk_50m);
    mon_a.delete();
    mon_x.delete();
    mon_y.delete();
  endtask

  initial begin
    int s0;
    int k;
    logic [7:0] b;
    bit saw_full;

    vt[0]  = '{8'h0A, 1'b0, 7'd0,  4'd0, 4'd0, 2'd1};
    vt[1]  = '{8'h0A, 1'b0, 7'd0,  4'd0, 4'd0, 2'd2};
    vt[2]  = '{8'h0A, 1'b0, 7'd0,  4'd0, 4'd0, 2'd3};
    vt[3]  = '{8'h61, 1'b1, 7'd0,  4'd6, 4'd1, 2'd3};
    vt[4]  = '{8'h62, 1'b1, 7'd8,  4'd6, 4'd2, 2'd3};
    vt[5]  = '{8'h63, 1'b1, 7'd16, 4'd6, 4'd3, 2'd3};
    vt[6]  = '{8'h64, 1'b1, 7'd24, 4'd6, 4'd4, 2'd3};
    vt[7]  = '{8'h65, 1'b1, 7'd32, 4'd6, 4'd5, 2'd3};
    vt[8]  = '{8'h0D, 1'b0, 7'd0,  4'd0, 4'd0, 2'd3};
    vt[9]  = '{8'h0A, 1'b0, 7'd0,  4'd0, 4'd0, 2'd0};
    vt[10] = '{8'h08, 1'b0, 7'd0,  4'd0, 4'd0, 2'd0};
    vt[11] = '{8'h01, 1'b0, 7'd0,  4'd0, 4'd0, 2'd0};
    vt[12] = '{8'h20, 1'b1, 7'd0,  4'd0, 4'd1, 2'd0};
    vt[13] = '{8'h7E, 1'b1, 7'd8,  4'd0, 4'd2, 2'd0};
    vt[14] = '{8'h7F, 1'b0, 7'd0,  4'd0, 4'd2, 2'd0};
    vt[15] = '{8'h08, 1'b0, 7'd0,  4'd0, 4'd1, 2'd0};
    vt[16] = '{8'h1F, 1'b0, 7'd0,  4'd0, 4'd1, 2'd0};

    // Reset values
    rst_n = 1'b0; in_valid = 1'b0; in_ascii = 8'h00; clr_req = 1'b0;
    repeat (3) @(negedge clk_50m);
    check("rst_in_ready", in_ready, 1);
    check("rst_cg_start", cg_start, 0);
    check("rst_cg_ascii", cg_ascii, 0);
    check("rst_cg_x", cg_x, 0);
    check("rst_cg_y", cg_y, 0);
    check("rst_cur_col", cur_col, 0);
    check("rst_cur_row", cur_row, 0);
    check("rst_idle", idle, 1);
    check("rst_err", err_timeout, 0);

    // Single character: start pulse exactly in cycle 3
    do_reset();
    auto_done = 1'b1; done_lat = 20;
    in_valid = 1'b1; in_ascii = 8'h41;
    @(negedge clk_50m); in_valid = 1'b0;
    check("t1_start_c1", cg_start, 0);
    @(negedge clk_50m);
    check("t1_start_c2", cg_start, 0);
    @(negedge clk_50m);
    check("t1_start_c3", cg_start, 1);
    check("t1_ascii", cg_ascii, 8'h41);
    check("t1_x", cg_x, 0);
    check("t1_y", cg_y, 0);
    @(negedge clk_50m);
    check("t1_start_c4", cg_start, 0);
    repeat (5) @(negedge clk_50m);
    check("t1_col_before_done", cur_col, 0);
    wait_idle("t1_idle", 100);
    check("t1_col", cur_col, 1);
    check("t1_row", cur_row, 0);
    check("t1_starts", mon_a.size(), 1);

    // 17 bytes with backpressure; line wrap after column 15
    do_reset();
    auto_done = 1'b1; done_lat = 10;
    saw_full = 1'b0;
    k = 0;
    for (int g = 0; g < 2000 && k < 17; g++) begin
      if (in_ready) begin
        in_valid = 1'b1;
        in_ascii = 8'h41 + 8'(k);
        k++;
      end else begin
        in_valid = 1'b0;
        saw_full = 1'b1;
      end
      @(negedge clk_50m);
    end
    in_valid = 1'b0;
    check("t2_saw_full", saw_full, 1);
    wait_idle("t2_idle", 2000);
    check("t2_starts", mon_a.size(), 17);
    for (int i = 0; i < 17; i++) begin
      if (i < mon_a.size()) begin
        check($sformatf("t2_cell%0d", i), {mon_a[i], mon_x[i], mon_y[i]},
              {8'h41 + 8'(i), (i < 16) ? 7'(i * 8) : 7'd0, (i < 16) ? 4'd0 : 4'd2});
      end
    end
    check("t2_col", cur_col, 1);
    check("t2_row", cur_row, 1);

    // Table of single-byte vectors: control codes and printable boundaries
    do_reset();
    auto_done = 1'b1; done_lat = 4;
    for (int i = 0; i < 17; i++) begin
      s0 = mon_a.size();
      push(vt[i].b);
      wait_idle($sformatf("vec%0d_idle", i), 200);
      check($sformatf("vec%0d_draw", i), mon_a.size() - s0, vt[i].draw);
      if (vt[i].draw && mon_a.size() > 0) begin
        check($sformatf("vec%0d_cell", i), {mon_a[$], mon_x[$], mon_y[$]},
              {vt[i].b, vt[i].x, vt[i].y});
      end
      check($sformatf("vec%0d_cursor", i), {cur_col, cur_row}, {vt[i].col, vt[i].row});
    end

    // clr_req during WAIT: current char finishes, then 64 blank cells
    do_reset();
    auto_done = 1'b1; done_lat = 10;
    push(8'h51);
    wait_start("t4_start", 20);
    @(negedge clk_50m);
    clr_req = 1'b1;
    @(negedge clk_50m);
    clr_req = 1'b0;
    wait_idle("t4_idle", 3000);
    check("t4_starts", mon_a.size(), 65);
    if (mon_a.size() > 0) check("t4_first", {mon_a[0], mon_x[0], mon_y[0]}, {8'h51, 7'd0, 4'd0});
    for (int i = 0; i < 64; i++) begin
      if (i + 1 < mon_a.size()) begin
        check($sformatf("t4_clr%0d", i), {mon_a[i+1], mon_x[i+1], mon_y[i+1]},
              {8'h20, 7'((i % 16) * 8), 4'((i / 16) * 2)});
      end
    end
    check("t4_cursor", {cur_col, cur_row}, 6'd0);
    check("t4_err", err_timeout, 0);

    // Form feed in the stream triggers the same clear
    mon_a.delete(); mon_x.delete(); mon_y.delete();
    done_lat = 2;
    push(8'h52);
    push(8'h0C);
    wait_idle("ff_idle", 3000);
    check("ff_starts", mon_a.size(), 65);
    if (mon_a.size() > 0) check("ff_first", {mon_a[0], mon_x[0], mon_y[0]}, {8'h52, 7'd0, 4'd0});
    if (mon_a.size() > 64) check("ff_last", {mon_a[64], mon_x[64], mon_y[64]}, {8'h20, 7'd120, 4'd6});
    check("ff_cursor", {cur_col, cur_row}, 6'd0);

    // Timeout with no done pulse; next queued byte still issued
    do_reset();
    push(8'h54);
    push(8'h55);
    wait_start("t5_start", 20);
    k = 0;
    while (!err_timeout && k < 300) begin
      @(negedge clk_50m);
      k++;
    end
    check("t5_err_cycle", k, 101);
    check("t5_col_after_to", cur_col, 1);
    wait_start("t5_start2", 20);
    check("t5_ascii2", cg_ascii, 8'h55);
    check("t5_x2", cg_x, 8);
    check("t5_err_sticky", err_timeout, 1);
    wait_idle("t5_idle", 300);
    check("t5_cursor", {cur_col, cur_row}, {4'd2, 2'd0});

    // Reset during WAIT with 3 bytes queued
    do_reset();
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    k = 0;
    while (mon_a.size() == 0 && k < 50) begin
      @(negedge clk_50m);
      k++;
    end
    check("t6_first_start", mon_a.size(), 1);
    repeat (3) @(negedge clk_50m);
    check("t6_busy", idle, 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_outputs", {in_ready, cg_start, cg_ascii, cg_x, cg_y, cur_col, cur_row, idle, err_timeout},
          {1'b1, 1'b0, 8'h00, 7'd0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0});
    @(negedge clk_50m);
    rst_n = 1'b1;
    mon_a.delete(); mon_x.delete(); mon_y.delete();
    repeat (50) @(negedge clk_50m);
    check("t6_no_start", mon_a.size(), 0);
    check("t6_idle", idle, 1);
    check("t6_in_ready", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
